// File: rtl/fx3_slave_fifo_model.sv
// Behavioural model of an FX3 GPIF-II slave FIFO: RX sink buffer (addr 0) and TX source buffer (addr 3).
// Optional statistics counters are built only when FX3_MODEL_STATS_EN is defined.
module fx3_slave_fifo_model #(
    parameter int BUF_WORDS      = 16,
    parameter int PARTIAL_THRESH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    input  logic [1:0]  fifo_addr,
    input  logic        slcs,
    input  logic        slwr,
    input  logic        slrd,
    input  logic        sloe,
    input  logic        pktend,
    output logic        rx_buf_full,
    output logic        rx_buf_partial,
    output logic        tx_buf_empty,
    output logic        tx_buf_partial,
    output logic [31:0] sink_data,
    output logic        sink_last,
    output logic        sink_valid,
    input  logic        sink_ready,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] stat_wr_words,
    output logic [15:0] stat_rd_words,
    output logic [15:0] stat_pkts,
    output logic        stat_ovf,
    output logic        stat_unf
);
    localparam int AW = $clog2(BUF_WORDS);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(BUF_WORDS);
    localparam logic [CW-1:0] RX_PART  = CW'(BUF_WORDS - PARTIAL_THRESH);
    localparam logic [CW-1:0] TX_PART  = CW'(PARTIAL_THRESH);

    logic [31:0]          rx_mem [BUF_WORDS];
    logic [31:0]          tx_mem [BUF_WORDS];
    logic [BUF_WORDS-1:0] rx_tag_q;
    logic [AW-1:0]        rx_wr_ptr_q, rx_rd_ptr_q, tx_wr_ptr_q, tx_rd_ptr_q;
    logic [CW-1:0]        rx_count_q, rx_count_d, tx_count_q, tx_count_d;
    logic [AW-1:0]        rx_last_idx, rd_addr_q;
    logic                 rd_req_q;
    logic [31:0]          stage1_q, stage2_q;
    logic                 rx_full_q, rx_part_q, tx_empty_q, tx_part_q;

    logic rx_sel, tx_sel, rx_wr_try, rx_push, rx_pop, rx_pkt_mark;
    logic tx_rd_try, tx_push, tx_pop;

    // Valid/ready: a transfer happens on an edge where both valid and ready are 1;
    // push/pop legality is judged on the pre-edge count, so full/empty never admit an extra beat.
    always_comb begin
        rx_sel      = slcs && (fifo_addr == 2'd0);
        tx_sel      = slcs && (fifo_addr == 2'd3);
        rx_wr_try   = rx_sel && slwr;
        rx_push     = rx_wr_try && (rx_count_q != FULL_CNT);
        rx_pop      = sink_valid && sink_ready;
        rx_last_idx = rx_wr_ptr_q - AW'(1);
        // A lone pktend tags the newest word only if it survives this edge.
        rx_pkt_mark = rx_sel && pktend && !slwr && (rx_count_q != '0)
                      && !(rx_pop && (rx_count_q == CW'(1)));
        tx_rd_try   = tx_sel && slrd;
        tx_pop      = tx_rd_try && (tx_count_q != '0);
        tx_push     = src_valid && src_ready;
        rx_count_d  = rx_count_q + CW'(rx_push) - CW'(rx_pop);
        tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
    end

    assign sink_valid = (rx_count_q != '0);
    assign sink_data  = rx_mem[rx_rd_ptr_q];
    assign sink_last  = sink_valid && rx_tag_q[rx_rd_ptr_q];
    assign src_ready  = (tx_count_q != FULL_CNT);
    assign data_out   = (sloe && tx_sel) ? stage2_q : 32'h0;

    assign rx_buf_full    = rx_full_q;
    assign rx_buf_partial = rx_part_q;
    assign tx_buf_empty   = tx_empty_q;
    assign tx_buf_partial = tx_part_q;

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr_q] <= data_in;
        if (tx_push) tx_mem[tx_wr_ptr_q] <= src_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_tag_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_count_q  <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_count_q  <= '0;
        end else begin
            if (rx_push) rx_tag_q[rx_wr_ptr_q] <= pktend;
            else if (rx_pkt_mark) rx_tag_q[rx_last_idx] <= 1'b1;
            if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + AW'(1);
            if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + AW'(1);
            if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + AW'(1);
            if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + AW'(1);
            rx_count_q <= rx_count_d;
            tx_count_q <= tx_count_d;
        end
    end

    // Read path: request register, then two data stages, giving data two edges after the pop.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_req_q  <= 1'b0;
            rd_addr_q <= '0;
            stage1_q  <= '0;
            stage2_q  <= '0;
        end else begin
            rd_req_q  <= tx_pop;
            rd_addr_q <= tx_rd_ptr_q;
            stage1_q  <= rd_req_q ? tx_mem[rd_addr_q] : 32'h0;
            stage2_q  <= stage1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_full_q  <= 1'b0;
            rx_part_q  <= 1'b0;
            tx_empty_q <= 1'b1;
            tx_part_q  <= 1'b1;
        end else begin
            rx_full_q  <= (rx_count_q == FULL_CNT);
            rx_part_q  <= (rx_count_q >= RX_PART);
            tx_empty_q <= (tx_count_q == '0);
            tx_part_q  <= (tx_count_q <= TX_PART);
        end
    end

`ifdef FX3_MODEL_STATS_EN
    logic [15:0] wr_words_q, rd_words_q, pkts_q;
    logic        ovf_q, unf_q;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_words_q <= '0;
            rd_words_q <= '0;
            pkts_q     <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            if (rx_push) wr_words_q <= wr_words_q + 16'd1;
            if (tx_pop)  rd_words_q <= rd_words_q + 16'd1;
            if ((rx_push && pktend) || rx_pkt_mark) pkts_q <= pkts_q + 16'd1;
            if (rx_wr_try && !rx_push) ovf_q <= 1'b1;
            if (tx_rd_try && !tx_pop)  unf_q <= 1'b1;
        end
    end
    assign stat_wr_words = wr_words_q;
    assign stat_rd_words = rd_words_q;
    assign stat_pkts     = pkts_q;
    assign stat_ovf      = ovf_q;
    assign stat_unf      = unf_q;
`else
    assign stat_wr_words = 16'd0;
    assign stat_rd_words = 16'd0;
    assign stat_pkts     = 16'd0;
    assign stat_ovf      = 1'b0;
    assign stat_unf      = 1'b0;
`endif

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// Directed bench for fx3_slave_fifo_model: RX fill/drain, packet tagging, TX read pipeline, reset flush.
module tb_fx3_slave_fifo_model;
`ifdef FX3_MODEL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk, reset_n;
    logic [31:0] data_in, data_out;
    logic [1:0]  fifo_addr;
    logic        slcs, slwr, slrd, sloe, pktend;
    logic        rx_buf_full, rx_buf_partial, tx_buf_empty, tx_buf_partial;
    logic [31:0] sink_data, src_data;
    logic        sink_last, sink_valid, sink_ready, src_valid, src_ready;
    logic [15:0] stat_wr_words, stat_rd_words, stat_pkts;
    logic        stat_ovf, stat_unf;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    fx3_slave_fifo_model #(.BUF_WORDS(16), .PARTIAL_THRESH(4)) dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_out(data_out),
        .fifo_addr(fifo_addr), .slcs(slcs), .slwr(slwr), .slrd(slrd), .sloe(sloe),
        .pktend(pktend), .rx_buf_full(rx_buf_full), .rx_buf_partial(rx_buf_partial),
        .tx_buf_empty(tx_buf_empty), .tx_buf_partial(tx_buf_partial),
        .sink_data(sink_data), .sink_last(sink_last), .sink_valid(sink_valid),
        .sink_ready(sink_ready), .src_data(src_data), .src_valid(src_valid),
        .src_ready(src_ready), .stat_wr_words(stat_wr_words), .stat_rd_words(stat_rd_words),
        .stat_pkts(stat_pkts), .stat_ovf(stat_ovf), .stat_unf(stat_unf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},   data_out, 32'h0);
        check({tag, "_svalid"}, {31'h0, sink_valid}, 32'h0);
        check({tag, "_slast"},  {31'h0, sink_last}, 32'h0);
        check({tag, "_sready"}, {31'h0, src_ready}, 32'h1);
        check({tag, "_rxfull"}, {31'h0, rx_buf_full}, 32'h0);
        check({tag, "_rxpart"}, {31'h0, rx_buf_partial}, 32'h0);
        check({tag, "_txemp"},  {31'h0, tx_buf_empty}, 32'h1);
        check({tag, "_txpart"}, {31'h0, tx_buf_partial}, 32'h1);
    endtask

    // drivers
    task automatic write_rx(input logic [31:0] d, input logic pe);
        slcs = 1'b1; fifo_addr = 2'd0; slwr = 1'b1; data_in = d; pktend = pe;
        tick();
        slwr = 1'b0; pktend = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; data_in = '0; fifo_addr = '0; slcs = 0; slwr = 0; slrd = 0;
        sloe = 0; pktend = 0; sink_ready = 0; src_data = '0; src_valid = 0;
        tick(); tick();
        check_reset_outputs("rst_during");
        reset_n = 1'b1;
        tick();
        check_reset_outputs("rst_after");

        // RX fill to full, then overflow attempt
        slcs = 1'b1; fifo_addr = 2'd0; slwr = 1'b1;
        for (int k = 0; k < 16; k++) begin
            data_in = k;
            tick();
            if (k == 11) check("rx_part_w12", {31'h0, rx_buf_partial}, 32'h0);
            if (k == 12) check("rx_part_w12p1", {31'h0, rx_buf_partial}, 32'h1);
            if (k == 15) check("rx_full_w16", {31'h0, rx_buf_full}, 32'h0);
        end
        check("ovf_before", {31'h0, stat_ovf}, 32'h0);
        data_in = 32'd99;
        tick();
        check("rx_full_w16p1", {31'h0, rx_buf_full}, 32'h1);
        slwr = 1'b0;
        tick();
        check("rx_full_hold", {31'h0, rx_buf_full}, 32'h1);
        check("stat_ovf", {31'h0, stat_ovf}, {31'h0, STATS});
        check("stat_wr16", {16'h0, stat_wr_words}, STATS ? 32'd16 : 32'd0);
        sink_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("rx_drain", sink_data, i);
            tick();
        end
        sink_ready = 1'b0;
        check("rx_drop17", {31'h0, sink_valid}, 32'h0);

        // packet end tagging
        write_rx(32'hA, 1'b0);
        write_rx(32'hB, 1'b0);
        write_rx(32'hC, 1'b0);
        pktend = 1'b1; tick(); pktend = 1'b0;
        sink_ready = 1'b1;
        check("pkt_a", sink_data, 32'hA);
        check("pkt_a_last", {31'h0, sink_last}, 32'h0);
        tick();
        check("pkt_b", sink_data, 32'hB);
        check("pkt_b_last", {31'h0, sink_last}, 32'h0);
        tick();
        check("pkt_c", sink_data, 32'hC);
        check("pkt_c_last", {31'h0, sink_last}, 32'h1);
        tick();
        sink_ready = 1'b0;
        check("stat_pkts1", {16'h0, stat_pkts}, STATS ? 32'd1 : 32'd0);
        pktend = 1'b1; tick(); pktend = 1'b0;
        write_rx(32'hD, 1'b0);
        slcs = 1'b0; slwr = 1'b1; data_in = 32'hBAD0; tick();
        slcs = 1'b1; fifo_addr = 2'd1; data_in = 32'hBAD1; tick();
        slwr = 1'b0; fifo_addr = 2'd0;
        check("pkt_d", sink_data, 32'hD);
        check("pkt_d_last", {31'h0, sink_last}, 32'h0);
        sink_ready = 1'b1; tick(); sink_ready = 1'b0;
        check("ignored_wr", {31'h0, sink_valid}, 32'h0);
        write_rx(32'hE, 1'b1);
        check("pkt_e", sink_data, 32'hE);
        check("pkt_e_last", {31'h0, sink_last}, 32'h1);
        sink_ready = 1'b1; tick(); sink_ready = 1'b0;
        check("stat_pkts2", {16'h0, stat_pkts}, STATS ? 32'd2 : 32'd0);
        check("stat_wr21", {16'h0, stat_wr_words}, STATS ? 32'd21 : 32'd0);

        // TX streaming read
        src_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            src_data = 32'h100 + i;
            exp_q.push_back(src_data);
            tick();
        end
        src_valid = 1'b0;
        check("tx_empty_8", {31'h0, tx_buf_empty}, 32'h0);
        check("tx_part_8", {31'h0, tx_buf_partial}, 32'h0);
        slcs = 1'b1; fifo_addr = 2'd3; sloe = 1'b1; slrd = 1'b1;
        for (int t = 1; t <= 11; t++) begin
            if (t == 9) slrd = 1'b0;
            tick();
            if (t >= 3 && t <= 10) check("rd_stream", data_out, exp_q.pop_front());
            else check("rd_stream_idle", data_out, 32'h0);
            if (t == 8) check("tx_empty_lastpop", {31'h0, tx_buf_empty}, 32'h0);
            if (t == 9) check("tx_empty_lastpop1", {31'h0, tx_buf_empty}, 32'h1);
            if (t == 10) begin
                sloe = 1'b0; #1;
                check("sloe_gate", data_out, 32'h0);
                sloe = 1'b1; fifo_addr = 2'd0; #1;
                check("addr_gate", data_out, 32'h0);
                fifo_addr = 2'd3;
            end
        end

        // TX underflow
        check("unf_before", {31'h0, stat_unf}, 32'h0);
        slrd = 1'b1; tick(); slrd = 1'b0;
        tick();
        check("unf_dout1", data_out, 32'h0);
        tick();
        check("unf_dout2", data_out, 32'h0);
        check("unf_txempty", {31'h0, tx_buf_empty}, 32'h1);
        check("stat_unf", {31'h0, stat_unf}, {31'h0, STATS});
        check("stat_rd8", {16'h0, stat_rd_words}, STATS ? 32'd8 : 32'd0);

        // TX full with simultaneous push attempt and read
        src_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            src_data = 32'h200 + i;
            exp_q.push_back(src_data);
            tick();
        end
        check("tx_full_ready", {31'h0, src_ready}, 32'h0);
        src_data = 32'h300; slrd = 1'b1;
        tick();
        check("tx_full_pop_ready", {31'h0, src_ready}, 32'h1);
        slrd = 1'b0;
        tick();
        exp_q.push_back(32'h300);
        check("tx_refill_ready", {31'h0, src_ready}, 32'h0);
        src_valid = 1'b0; slrd = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            if (t == 17) slrd = 1'b0;
            tick();
            if (t == 1 || (t >= 3 && t <= 18)) check("full_stream", data_out, exp_q.pop_front());
            else check("full_stream_gap", data_out, 32'h0);
        end

        // TX empty with simultaneous push and read
        src_data = 32'h400; src_valid = 1'b1; slrd = 1'b1;
        tick();
        check("emp_ready", {31'h0, src_ready}, 32'h1);
        src_valid = 1'b0; slrd = 1'b0;
        tick();
        check("emp_count1", {31'h0, tx_buf_empty}, 32'h0);
        tick();
        check("emp_dout", data_out, 32'h0);
        slrd = 1'b1; tick(); slrd = 1'b0;
        tick();
        check("emp_drained", {31'h0, tx_buf_empty}, 32'h1);
        tick();
        check("emp_word", data_out, 32'h400);

        // reset between reads flushes the pipeline
        src_valid = 1'b1;
        src_data = 32'h500; tick();
        src_data = 32'h501; tick();
        src_valid = 1'b0;
        slrd = 1'b1; tick();
        slrd = 1'b0; reset_n = 1'b0; tick();
        check_reset_outputs("midrst_during");
        reset_n = 1'b1; slrd = 1'b1; tick(); slrd = 1'b0;
        check_reset_outputs("midrst_after");
        check("midrst_stat_wr", {16'h0, stat_wr_words}, 32'h0);
        tick();
        check("midrst_dout1", data_out, 32'h0);
        tick();
        check("midrst_dout2", data_out, 32'h0);
        tick();
        check("midrst_dout3", data_out, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
